irq_dma_guard: RTL and testbench

//  Multi-region successor to the single-region IRQ monitor. Watches the CPU PC, IRQ line and DMA bus against

---
 rtl/irq_dma_guard_pkg.sv | 27 ++
 rtl/irq_dma_guard_region_cmp.sv | 20 ++
 rtl/irq_dma_guard.sv | 163 ++++++++++++++++
 tb/tb_irq_dma_guard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_dma_guard_pkg.sv
// ---------------------------------------------------------------------------
// irq_dma_guard_pkg
//   Shared definitions for the multi-region IRQ/DMA guard.
//   - guard_state_e : FSM state encoding, visible on state_o
//   - irq_cause_idx : bit position of the IRQ-violation cause for a region
//   - dma_cause_idx : bit position of the DMA-violation cause for a region
// ---------------------------------------------------------------------------
package irq_dma_guard_pkg;

  // KILL counts down the minimum hold, WAIT parks until the handler fetch,
  // RUN is normal operation with the MCU out of reset.
  typedef enum logic [1:0] {
    KILL = 2'b00,
    WAIT = 2'b01,
    RUN  = 2'b10
  } guard_state_e;

  // The low half of viol_cause holds IRQ causes, the upper half DMA causes.
  function automatic int irq_cause_idx(input int region);
    return region;
  endfunction

  function automatic int dma_cause_idx(input int nreg, input int region);
    return nreg + region;
  endfunction

endpackage

// File: rtl/irq_dma_guard_region_cmp.sv
// ---------------------------------------------------------------------------
// guard_region_cmp
//   Purely combinational inclusive range check: hit = BASE <= addr <= LAST
//   (unsigned).
//   Ports:
//     addr  in   AW   address or PC to test
//     hit   out  1    address lies inside [BASE, LAST]
// ---------------------------------------------------------------------------
module guard_region_cmp #(
  parameter int            AW   = 16,
  parameter logic [AW-1:0] BASE = '0,
  parameter logic [AW-1:0] LAST = '1
) (
  input  logic [AW-1:0] addr,
  output logic          hit
);

  assign hit = (addr >= BASE) && (addr <= LAST);

endmodule

// File: rtl/irq_dma_guard.sv
// ---------------------------------------------------------------------------
// irq_dma_guard
//   Watches the CPU PC, the IRQ line and the DMA bus against NREG protected
//   regions. An illegal IRQ or DMA access asserts a registered reset to the
//   MCU, held for at least RST_HOLD cycles and released only once the CPU
//   fetches from RESET_HANDLER. Sticky per-region causes and a saturating
//   violation count are kept for attestation firmware.
//   Ports:
//     clk         in   1        system clock
//     reset       in   1        asynchronous, active-high
//     pc          in   AW       current CPU program counter
//     dma_addr    in   AW       DMA address
//     dma_en      in   1        DMA access valid this cycle
//     irq         in   1        CPU is taking an interrupt this cycle
//     cause_clr   in   1        clears viol_cause (honoured in RUN only)
//     kill_rst    out  1        reset request to the MCU
//     viol_cause  out  2*NREG   sticky causes: [i] IRQ, [NREG+i] DMA
//     viol_count  out  CW       saturating count of violation events
//     state_o     out  2        current FSM state
// ---------------------------------------------------------------------------
module irq_dma_guard
  import irq_dma_guard_pkg::*;
#(
  parameter int                 AW            = 16,
  parameter int                 NREG          = 2,
  parameter logic [NREG*AW-1:0] REG_BASE      = {16'hA000, 16'hE000},
  parameter logic [NREG*AW-1:0] REG_LAST      = {16'hA7FE, 16'hEFFE},
  parameter logic [NREG-1:0]    IRQ_ALLOW     = 2'b00,
  parameter logic [NREG-1:0]    DMA_GUARD     = 2'b11,
  parameter logic [AW-1:0]      RESET_HANDLER = 16'h0000,
  parameter int                 RST_HOLD      = 4,
  parameter int                 CW            = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     pc,
  input  logic [AW-1:0]     dma_addr,
  input  logic              dma_en,
  input  logic              irq,
  input  logic              cause_clr,
  output logic              kill_rst,
  output logic [2*NREG-1:0] viol_cause,
  output logic [CW-1:0]     viol_count,
  output logic [1:0]        state_o
);

  localparam int               HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [CW-1:0]     COUNT_MAX   = '1;

  logic [NREG-1:0]   pc_hit;
  logic [NREG-1:0]   dma_hit;
  logic [NREG-1:0]   irq_v;
  logic [NREG-1:0]   dma_v;
  logic [2*NREG-1:0] cause_set;
  logic              viol;

  guard_state_e      state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              kill_rst_next;
  logic [2*NREG-1:0] cause_next;
  logic [CW-1:0]     count_next;

  // One PC comparator and one DMA comparator per region. Regions are checked
  // independently, so overlapping regions can flag together.
  for (genvar i = 0; i < NREG; i++) begin : g_region
    guard_region_cmp #(
      .AW   (AW),
      .BASE (REG_BASE[i*AW +: AW]),
      .LAST (REG_LAST[i*AW +: AW])
    ) u_pc_cmp (
      .addr (pc),
      .hit  (pc_hit[i])
    );

    guard_region_cmp #(
      .AW   (AW),
      .BASE (REG_BASE[i*AW +: AW]),
      .LAST (REG_LAST[i*AW +: AW])
    ) u_dma_cmp (
      .addr (dma_addr),
      .hit  (dma_hit[i])
    );

    assign irq_v[i] = irq && pc_hit[i] && !IRQ_ALLOW[i];
    assign dma_v[i] = dma_en && dma_hit[i] && DMA_GUARD[i];
    assign cause_set[irq_cause_idx(i)]       = irq_v[i];
    assign cause_set[dma_cause_idx(NREG, i)] = dma_v[i];
  end

  assign viol = |cause_set;

  // Next-state logic. A violation in any state restarts the full hold, so the
  // reset is always held at least RST_HOLD cycles after the last violation.
  // A handler fetch only counts in WAIT; during KILL it is ignored. The
  // unused encoding falls back to KILL so a corrupted state fails safe.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      KILL: begin
        if (viol) begin
          hold_next = HOLD_RELOAD;
        end else if (hold_cnt == '0) begin
          state_next = WAIT;
        end else begin
          hold_next = hold_cnt - 1'b1;
        end
      end
      WAIT: begin
        if (viol) begin
          state_next = KILL;
          hold_next  = HOLD_RELOAD;
        end else if (pc == RESET_HANDLER) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (viol) begin
          state_next = KILL;
          hold_next  = HOLD_RELOAD;
        end
      end
      default: begin
        state_next = KILL;
        hold_next  = HOLD_RELOAD;
      end
    endcase
  end

  // Reset request, cause and count updates. Newly set cause bits win over a
  // simultaneous clear, and only violations seen in RUN are counted so one
  // attack is one event even if it repeats while the MCU is held in reset.
  always_comb begin
    kill_rst_next = (state_next != RUN);
    cause_next    = ((cause_clr && (state == RUN)) ? '0 : viol_cause) | cause_set;
    count_next    = viol_count;
    if ((state == RUN) && viol && (viol_count != COUNT_MAX)) begin
      count_next = viol_count + CW'(1);
    end
  end

  // All state is registered; reset puts the MCU straight back into reset
  // with a fresh hold and cleared attestation records.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= KILL;
      hold_cnt   <= HOLD_RELOAD;
      kill_rst   <= 1'b1;
      viol_cause <= '0;
      viol_count <= '0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_next;
      kill_rst   <= kill_rst_next;
      viol_cause <= cause_next;
      viol_count <= count_next;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_irq_dma_guard.sv
// ---------------------------------------------------------------------------
// tb_irq_dma_guard
//   Self-checking bench for irq_dma_guard with default parameters.
//   Region 0 = 0xE000..0xEFFE, region 1 = 0xA000..0xA7FE, handler at 0x0000.
//   A reference model predicts the outputs for every driven cycle; the
//   prediction is queued and compared one clock later.
// ---------------------------------------------------------------------------
module tb_irq_dma_guard;

  typedef struct {
    logic       kill;
    logic [3:0] cause;
    logic [7:0] count;
    logic [1:0] state;
  } expect_t;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        irq;
  logic        cause_clr;
  logic        kill_rst;
  logic [3:0]  viol_cause;
  logic [7:0]  viol_count;
  logic [1:0]  state_o;

  expect_t     scoreboard[$];
  int          check_count = 0;
  int          pass_count  = 0;

  // Reference model state
  logic [1:0]  m_state;
  int          m_hold;
  logic [3:0]  m_cause;
  logic [7:0]  m_count;

  irq_dma_guard dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .dma_addr   (dma_addr),
    .dma_en     (dma_en),
    .irq        (irq),
    .cause_clr  (cause_clr),
    .kill_rst   (kill_rst),
    .viol_cause (viol_cause),
    .viol_count (viol_count),
    .state_o    (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic in_region(input int r, input logic [15:0] a);
    if (r == 0) return (a >= 16'hE000) && (a <= 16'hEFFE);
    return (a >= 16'hA000) && (a <= 16'hA7FE);
  endfunction

  task automatic modelReset();
    m_state = 2'b00;
    m_hold  = 3;
    m_cause = 4'b0000;
    m_count = 8'h00;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare
  // the oldest prediction once the DUT has clocked.
  task automatic applyStimulus(input logic [15:0] p, input logic i,
                               input logic de, input logic [15:0] da,
                               input logic clr);
    logic [1:0] iv, dv;
    logic       v;
    expect_t    e, got;
    pc = p; irq = i; dma_en = de; dma_addr = da; cause_clr = clr;
    iv[0] = i && in_region(0, p);
    iv[1] = i && in_region(1, p);
    dv[0] = de && in_region(0, da);
    dv[1] = de && in_region(1, da);
    v = |{dv, iv};
    if (clr && m_state == 2'b10) m_cause = 4'b0000;
    m_cause = m_cause | {dv, iv};
    if (m_state == 2'b10 && v && m_count != 8'hFF) m_count = m_count + 8'd1;
    case (m_state)
      2'b00: begin
        if (v) m_hold = 3;
        else if (m_hold == 0) m_state = 2'b01;
        else m_hold = m_hold - 1;
      end
      2'b01: begin
        if (v) begin m_state = 2'b00; m_hold = 3; end
        else if (p == 16'h0000) m_state = 2'b10;
      end
      default: begin
        if (v) begin m_state = 2'b00; m_hold = 3; end
      end
    endcase
    e.kill = (m_state != 2'b10); e.cause = m_cause; e.count = m_count; e.state = m_state;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    got = scoreboard.pop_front();
    checkOutput("kill_rst",   {31'd0, kill_rst},   {31'd0, got.kill});
    checkOutput("viol_cause", {28'd0, viol_cause}, {28'd0, got.cause});
    checkOutput("viol_count", {24'd0, viol_count}, {24'd0, got.count});
    checkOutput("state_o",    {30'd0, state_o},    {30'd0, got.state});
  endtask

  // Fetch the handler until the model says RUN, bounded.
  task automatic recover();
    for (int n = 0; n < 12 && m_state != 2'b10; n++) applyStimulus(16'h0000, 0, 0, 16'h0, 0);
    checkOutput("recover_run", {30'd0, state_o}, 32'd2);
  endtask

  initial begin
    int start_count;
    reset = 1'b1; pc = 16'h0100; dma_addr = 16'h0; dma_en = 0; irq = 0; cause_clr = 0;
    modelReset();
    #23;
    checkOutput("rst_kill",  {31'd0, kill_rst},   32'd1);
    checkOutput("rst_state", {30'd0, state_o},    32'd0);
    checkOutput("rst_cause", {28'd0, viol_cause}, 32'd0);
    checkOutput("rst_count", {24'd0, viol_count}, 32'd0);
    #4 reset = 1'b0;

    // 1: no handler fetch keeps the MCU in reset, then handler releases it
    for (int n = 0; n < 8; n++) applyStimulus(16'h0100, 0, 0, 16'h0, 0);
    checkOutput("t1_held", {31'd0, kill_rst}, 32'd1);
    applyStimulus(16'h0000, 0, 0, 16'h0, 0);
    checkOutput("t1_release", {31'd0, kill_rst}, 32'd0);
    checkOutput("t1_run", {30'd0, state_o}, 32'd2);

    // 2: IRQ in region 0, then minimum hold before release
    applyStimulus(16'hE000, 1, 0, 16'h0, 0);
    checkOutput("t2_kill", {31'd0, kill_rst}, 32'd1);
    checkOutput("t2_cause", {28'd0, viol_cause}, 32'h1);
    checkOutput("t2_count", {24'd0, viol_count}, 32'd1);
    for (int n = 0; n < 4; n++) applyStimulus(16'h0000, 0, 0, 16'h0, 0);
    checkOutput("t2_hold", {31'd0, kill_rst}, 32'd1);
    applyStimulus(16'h0000, 0, 0, 16'h0, 0);
    checkOutput("t2_released", {31'd0, kill_rst}, 32'd0);

    // 3: region boundaries
    applyStimulus(16'hDFFE, 1, 0, 16'h0, 0);
    applyStimulus(16'hF000, 1, 0, 16'h0, 0);
    checkOutput("t3_outside", {31'd0, kill_rst}, 32'd0);
    applyStimulus(16'hEFFE, 1, 0, 16'h0, 0);
    checkOutput("t3_last", {31'd0, kill_rst}, 32'd1);
    recover();
    applyStimulus(16'h0000, 0, 1, 16'hA7FE, 0);
    checkOutput("t3_dma_last", {31'd0, viol_cause[3]}, 32'd1);
    recover();
    applyStimulus(16'h0000, 0, 1, 16'hA800, 0);
    checkOutput("t3_dma_past", {31'd0, kill_rst}, 32'd0);

    // 4: simultaneous IRQ (region 1) and DMA (region 0) violations
    applyStimulus(16'h0000, 0, 0, 16'h0, 1);
    checkOutput("t4_clr", {28'd0, viol_cause}, 32'h0);
    start_count = int'(viol_count);
    applyStimulus(16'hA100, 1, 1, 16'hE010, 0);
    checkOutput("t4_cause", {28'd0, viol_cause}, 32'h6);
    checkOutput("t4_count", {24'd0, viol_count}, 32'(start_count + 1));
    recover();

    // 5: clear races and clear outside RUN
    applyStimulus(16'h0000, 0, 0, 16'h0, 1);
    applyStimulus(16'hE100, 1, 0, 16'h0, 0);
    recover();
    checkOutput("t5_cause1", {28'd0, viol_cause}, 32'h1);
    applyStimulus(16'h0000, 0, 0, 16'h0, 1);
    checkOutput("t5_cleared", {28'd0, viol_cause}, 32'h0);
    applyStimulus(16'h0000, 0, 1, 16'hE000, 1);
    checkOutput("t5_set_wins", {28'd0, viol_cause}, 32'h4);
    applyStimulus(16'h0100, 0, 0, 16'h0, 1);
    checkOutput("t5_clr_in_kill", {28'd0, viol_cause}, 32'h4);
    recover();

    // 6: saturation, then asynchronous reset in the middle of KILL
    for (int n = 0; n < 300 && m_count != 8'hFF; n++) begin
      applyStimulus(16'hE000, 1, 0, 16'h0, 0);
      recover();
    end
    checkOutput("t6_sat", {24'd0, viol_count}, 32'hFF);
    applyStimulus(16'hE000, 1, 1, 16'hA000, 0);
    checkOutput("t6_stays", {24'd0, viol_count}, 32'hFF);
    applyStimulus(16'h0100, 0, 0, 16'h0, 0);
    checkOutput("t6_midkill", {30'd0, state_o}, 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_async_kill",  {31'd0, kill_rst},   32'd1);
    checkOutput("t6_async_state", {30'd0, state_o},    32'd0);
    checkOutput("t6_async_cause", {28'd0, viol_cause}, 32'd0);
    checkOutput("t6_async_count", {24'd0, viol_count}, 32'd0);
    modelReset();
    #10 reset = 1'b0;
    for (int n = 0; n < 6; n++) applyStimulus(16'h0000, 0, 0, 16'h0, 0);
    checkOutput("t6_rearm", {31'd0, kill_rst}, 32'd0);
    checkOutput("sb_empty", 32'(scoreboard.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
